// File: rtl/bram_sdp_ctrl.sv
// rtl/bram_sdp_ctrl.sv - simple-dual-port block RAM with byte enables, read pipeline and clear sequencer
module bram_sdp_ctrl #(
   parameter int ADDRESSWIDTH   = 10,
   parameter int BITWIDTH       = 32,
   parameter int DEPTH          = 1024,
   parameter int OUT_REG        = 0,
   parameter int RDW_MODE       = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr_start,
   output logic                      busy,
   input  logic                      wr_en,
   input  logic [ADDRESSWIDTH-1:0]   wr_addr,
   input  logic [BITWIDTH-1:0]       wr_data,
   input  logic [BITWIDTH/8-1:0]     wr_be,
   input  logic                      rd_en,
   input  logic [ADDRESSWIDTH-1:0]   rd_addr,
   output logic [BITWIDTH-1:0]       rd_data,
   output logic                      rd_valid
);

   localparam int NBYTES = BITWIDTH / 8;
   localparam int AIW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDRESSWIDTH:0]   DEPTH_W   = (ADDRESSWIDTH+1)'(DEPTH);
   localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR = ADDRESSWIDTH'(DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                    state, state_nxt;
   logic [ADDRESSWIDTH-1:0]   clr_cnt, clr_cnt_nxt;
   logic                      wr_ok, rd_acc, rd_oor;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
         clr_cnt <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      case (state)
         IDLE: begin
            if (clr_start) begin
               state_nxt   = CLEAR;
               clr_cnt_nxt = '0;
            end
         end
         CLEAR: begin
            if (clr_cnt == LAST_ADDR) begin
               state_nxt   = IDLE;
               clr_cnt_nxt = '0;
            end else begin
               clr_cnt_nxt = clr_cnt + 1'b1;
            end
         end
      endcase
   end

   assign busy   = (state == CLEAR);
   assign wr_ok  = wr_en && !busy && ({1'b0, wr_addr} < DEPTH_W);
   assign rd_acc = rd_en && !busy;
   assign rd_oor = ({1'b0, rd_addr} >= DEPTH_W);

   // Out-of-range addresses are filtered above, so truncating the index is safe.
   (* ram_style = "block" *) logic [BITWIDTH-1:0] mem [DEPTH];
   logic [BITWIDTH-1:0] ram_q;

   always_ff @(posedge clk) begin
      if (busy) begin
         mem[clr_cnt[AIW-1:0]] <= '0;
      end else if (wr_ok) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (wr_be[i]) mem[wr_addr[AIW-1:0]][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
      if (rd_acc && !rd_oor) ram_q <= mem[rd_addr[AIW-1:0]];
   end

   // Write-first collisions are served by overlaying the captured write bytes on the old word.
   logic                rd_zero;
   logic [NBYTES-1:0]   byp_be;
   logic [BITWIDTH-1:0] byp_data;
   logic                vld1;
   logic [BITWIDTH-1:0] s1_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_zero  <= 1'b1;
         byp_be   <= '0;
         byp_data <= '0;
         vld1     <= 1'b0;
      end else begin
         vld1 <= rd_acc;
         if (rd_acc) begin
            rd_zero  <= rd_oor;
            byp_be   <= (RDW_MODE != 0 && wr_ok && wr_addr == rd_addr) ? wr_be : '0;
            byp_data <= wr_data;
         end
      end
   end

   always_comb begin
      s1_data = '0;
      if (!rd_zero) begin
         for (int i = 0; i < NBYTES; i++) begin
            s1_data[8*i +: 8] = byp_be[i] ? byp_data[8*i +: 8] : ram_q[8*i +: 8];
         end
      end
   end

   if (OUT_REG != 0) begin : g_oreg
      logic                vld2;
      logic [BITWIDTH-1:0] data_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld2   <= 1'b0;
            data_q <= '0;
         end else begin
            vld2 <= vld1;
            if (vld1) data_q <= s1_data;
         end
      end
      assign rd_data  = data_q;
      assign rd_valid = vld2;
   end else begin : g_noreg
      assign rd_data  = s1_data;
      assign rd_valid = vld1;
   end

endmodule

// File: doc/bram_sdp_ctrl.md
Name: bram_sdp_ctrl

Overview:
Parametrised simple-dual-port block RAM with a registered-address write/read core inferred as BRAM (ram_style = "block"). It adds the following on top of the single-port store:
- per-byte write enables
- configurable read latency with a read-valid pipeline
- defined same-address read/write collision behaviour
- a hardware clear sequencer that zeroes the array after reset or on request
It is the standard on-chip buffer for PL datapaths and AXI-side staging.

Parameters:
ADDRESSWIDTH, 10, address bus width; DEPTH <= 2**ADDRESSWIDTH.
BITWIDTH, 32, data width; must be a multiple of 8; NBYTES = BITWIDTH/8.
DEPTH, 1024, number of words.
OUT_REG, 0, 1 adds an output register stage; read latency L = 1 + OUT_REG.
RDW_MODE, 0, same-address collision: 0 = read-first (old data), 1 = write-first (new merged data).
CLEAR_ON_RESET, 1, 1 = run the clear sequence automatically after reset.

Ports:
clk  in  1  clock, all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
clr_start  in  1  pulse requesting a full-array clear; sampled only when idle.
busy  out  1  clear sequence in progress; user accesses are ignored while high.
wr_en  in  1  write strobe.
wr_addr  in  ADDRESSWIDTH  write address.
wr_data  in  BITWIDTH  write data.
wr_be  in  NBYTES  byte enables; bit i covers wr_data[8i+7:8i].
rd_en  in  1  read strobe.
rd_addr  in  ADDRESSWIDTH  read address.
rd_data  out  BITWIDTH  read data; holds its value between reads.
rd_valid  out  1  one-cycle pulse marking rd_data valid.

Behaviour:
- Reset (async, rst_n low):
  - rd_data = 0, rd_valid = 0, valid pipeline cleared.
  - Clear counter = 0.
  - busy = CLEAR_ON_RESET.
  - The array contents are not reset.
- Writes: when wr_en && !busy at an edge, each byte i with wr_be[i] = 1 is written at wr_addr. Bytes with wr_be[i] = 0 are unchanged. wr_addr >= DEPTH drops the write.
- Reads:
  - rd_en && !busy at edge k → rd_data updated and rd_valid = 1 after edge k+L-1 (L = 1: visible in cycle k+1; L = 2: visible in cycle k+2).
  - Back-to-back reads are fully pipelined, one per cycle.
  - rd_addr >= DEPTH returns 0, with rd_valid still asserted.
- Collision: rd_en && wr_en at the same edge with rd_addr == wr_addr.
  - RDW_MODE 0: returns the pre-write word.
  - RDW_MODE 1: returns the merged word (new bytes where wr_be = 1, old bytes elsewhere). This is implemented with a bypass register, not the BRAM port mode.
  - A read issued the cycle after a write always sees the written data.
- Clear FSM, states IDLE and CLEAR:
  - IDLE → CLEAR when clr_start is sampled high with busy = 0. busy rises the cycle after the request.
  - In CLEAR: one word written per cycle with value 0, at addresses 0 up to DEPTH-1 in order. busy stays high for exactly DEPTH cycles, then the FSM returns to IDLE.
  - CLEAR_ON_RESET = 1: after reset the FSM starts in CLEAR, with address 0 written at the first edge after rst_n deasserts. busy is high for DEPTH cycles counted from that edge.
  - clr_start is ignored while busy.
  - wr_en and rd_en are ignored while busy; no rd_valid is generated for them.
  - Reads accepted before busy rose complete normally through the pipeline.
  - Reset asserted mid-clear aborts the sequence. Afterwards, the clear restarts from address 0 if CLEAR_ON_RESET = 1; otherwise the FSM stays IDLE with partially cleared contents.
- Simultaneous clr_start and wr_en/rd_en in IDLE: the user access is performed at that edge, then the clear begins. The clear wins for that address.

Test Plan:
1. DEPTH = 16, CLEAR_ON_RESET = 1, OUT_REG = 0: release rst_n → busy high exactly 16 cycles; then reading addresses 0..15 back-to-back returns 0 each with rd_valid one cycle after rd_en.
2. Write 0xDEADBEEF at address 5 with wr_be = 4'b1111, then write 0x000000AA with wr_be = 4'b0001 → read address 5 returns 0xDEADBEAA.
3. RDW_MODE 0 vs 1: address 3 holds 0x11111111; same-edge write 0x22222222 (wr_be = 4'b1111) and read of address 3 → 0x11111111 (mode 0) / 0x22222222 (mode 1); next read returns 0x22222222 in both.
4. OUT_REG = 1: reads at addresses 1, 2, 3 on consecutive edges → rd_valid high for 3 cycles starting 2 cycles after the first rd_en, with data in order; rd_data holds the last value afterwards.
5. clr_start in IDLE with rd_en to address 7 (0x5A5A5A5A) on the same edge → rd_data = 0x5A5A5A5A, rd_valid once; busy for 16 cycles; wr_en/rd_en during busy produce no rd_valid and no writes; address 7 reads 0 afterwards.
6. Assert rst_n low at clear cycle 8 of 16 → outputs reset immediately; on release busy runs a full 16 cycles again (CLEAR_ON_RESET = 1); a read of address 2 at 0x000000FF and out-of-range address 20 (ADDRESSWIDTH = 5) returns 0.
